// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// FSM state and read-return owner encodings live here so top and bench agree.
package dmem_port_arbiter_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;

  // Bits needed to hold 0..max inclusive; never less than one.
  function automatic int ctr_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the debug requester.
// Clear has priority over increment; o_at_max flags the forced-win threshold.
module dmem_port_arbiter_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = ctr_width(STARVE_MAX);
  localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the pipeline (P) and debug (D) ports.
// P has default priority; D wins after STARVE_MAX denied cycles, or always while locked.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_p_req,
  input  logic                i_p_we,
  input  logic [DATA_W/8-1:0] i_p_be,
  input  logic [ADDR_W-1:0]   i_p_addr,
  input  logic [DATA_W-1:0]   i_p_wdata,
  output logic                o_p_gnt,
  output logic                o_p_stall,
  output logic                o_p_rvalid,
  output logic [DATA_W-1:0]   o_p_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [DATA_W/8-1:0] i_d_be,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic                i_d_lock,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_d_locked,
  output logic                o_m_en,
  output logic                o_m_we,
  output logic [DATA_W/8-1:0] o_m_be,
  output logic [ADDR_W-1:0]   o_m_addr,
  output logic [DATA_W-1:0]   o_m_wdata,
  input  logic [DATA_W-1:0]   i_m_rdata
);

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_rd_owner;
  logic   w_p_gnt;
  logic   w_d_gnt;
  logic   w_at_max;
  logic   w_starve_inc;
  logic   w_starve_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are gated by reset so nothing reaches dm while reset is held.
  always_comb begin
    w_state_nxt = i_d_lock ? ST_LOCK : ST_ARB;
    w_p_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_ARB: begin
          if (i_p_req && i_d_req) begin
            w_d_gnt = w_at_max;
            w_p_gnt = !w_at_max;
          end else begin
            w_p_gnt = i_p_req;
            w_d_gnt = i_d_req;
          end
        end
        ST_LOCK: begin
          w_d_gnt = i_d_req;
        end
        default: begin
          w_p_gnt = 1'b0;
          w_d_gnt = 1'b0;
        end
      endcase
    end
  end

  assign w_starve_inc = i_d_req & ~w_d_gnt;
  assign w_starve_clr = w_d_gnt | ~i_d_req | (r_state == ST_LOCK);

  dmem_port_arbiter_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_starve_inc),
    .i_clr   (w_starve_clr),
    .o_at_max(w_at_max)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_owner <= OWN_NONE;
    end else if (w_p_gnt && !i_p_we) begin
      r_rd_owner <= OWN_P;
    end else if (w_d_gnt && !i_d_we) begin
      r_rd_owner <= OWN_D;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  assign o_p_gnt    = w_p_gnt;
  assign o_d_gnt    = w_d_gnt;
  assign o_p_stall  = i_rst_n & i_p_req & ~w_p_gnt;
  assign o_d_locked = (r_state == ST_LOCK);

  assign o_p_rvalid = (r_rd_owner == OWN_P);
  assign o_d_rvalid = (r_rd_owner == OWN_D);
  assign o_p_rdata  = o_p_rvalid ? i_m_rdata : '0;
  assign o_d_rdata  = o_d_rvalid ? i_m_rdata : '0;

  // Memory side follows the winner; P fields are shown when idle (m_en=0).
  assign o_m_en    = w_p_gnt | w_d_gnt;
  assign o_m_we    = w_d_gnt ? i_d_we    : (w_p_gnt & i_p_we);
  assign o_m_be    = w_d_gnt ? i_d_be    : i_p_be;
  assign o_m_addr  = w_d_gnt ? i_d_addr  : i_p_addr;
  assign o_m_wdata = w_d_gnt ? i_d_wdata : i_p_wdata;

endmodule
